alu_cc_unit: RTL and testbench
==============================

Name: alu_cc_unit

Overview:
- Datapath execute stage, directly downstream of the register unit.
- Consumes SR1_out (operand A) and SR2_MUX_out (operand B) and computes a registered ALU result for the bus.
- Owns the LC-3 condition-code register (N/Z/P) and branch-enable (BEN) register.
- Adds an iterative 16-cycle shift-add multiply under a Start/Done handshake, so the control FSM waits on Busy/Done instead of assuming a fixed latency.

Parameters:
- MUL_CYCLES, 16, number of MUL iteration cycles; fixed equal to operand width, not to be overridden.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_al  in  1  asynchronous, active-low reset.
- Start  in  1  operation request; sampled only in IDLE.
- ALUK  in  3  opcode: 000 ADD, 001 AND, 010 NOT(A), 011 PASSA, 100 MUL; 101-111 behave as PASSA.
- A  in  16  operand A (SR1_out).
- B  in  16  operand B (SR2_MUX_out).
- ALU_out  out  16  registered result.
- Busy  out  1  high while in MUL state.
- Done  out  1  one-cycle completion pulse.
- Bus_Data  in  16  value being written to a register, for CC update.
- LD_CC  in  1  load N/Z/P from Bus_Data.
- IR_nzp  in  3  IR[11:9] branch mask.
- LD_BEN  in  1  load BEN.
- N, Z, P  out  1 each  condition codes.
- BEN  out  1  branch enable.

Behaviour:
- Reset (Reset_al low, asynchronous):
  - State IDLE.
  - ALU_out=0x0000, Done=0, Busy=0.
  - N=Z=P=0, BEN=0.
  - Internal multiplicand, multiplier, accumulator and count registers cleared.
- FSM states: IDLE, MUL, DONE.
- IDLE, Start=1, ALUK != 100:
  - At edge k, ALU_out gets the result.
  - Next state DONE; Done=1 for the cycle after edge k.
  - Latency 1.
- IDLE, Start=1, ALUK=100:
  - At edge k: capture mcand=A, mplr=B, acc=0, cnt=0.
  - Next state MUL.
- MUL, on each edge:
  - If mplr[0]=1, acc += mcand.
  - mcand <<= 1; mplr >>= 1; cnt++.
  - On the edge where cnt==15: ALU_out gets the low 16 bits of the next accumulator value; next state DONE.
  - MUL occupies edges k+1..k+16.
  - Done is high in the cycle after edge k+16, so total latency is 16 cycles after capture.
- DONE: Done=1, Busy=0; next state IDLE unconditionally.
- Start is ignored in MUL and DONE. The request is dropped, not queued.
- A and B are sampled only at capture. Changes during MUL have no effect.
- Arithmetic:
  - ADD is 16-bit two's-complement with wrap; carry discarded.
  - MUL is unsigned; result is the low 16 bits of the product.
- ALU_out holds its value until the next operation completes.
- LD_CC=1 at an edge:
  - N=Bus_Data[15].
  - Z=(Bus_Data==0).
  - P=~N&~Z.
  - Exactly one flag is set after any load.
- LD_BEN=1 at an edge: BEN = |(IR_nzp & {N,Z,P}), using the N/Z/P values held before that edge. If LD_CC and LD_BEN are asserted on the same edge, BEN sees the old codes.
- The CC/BEN logic is independent of the ALU FSM and operates in any state.
- Reset mid-MUL aborts immediately: IDLE, outputs at reset values, no Done pulse.

Optional Feature:
- Macro ALU_OVF_FLAG_EN.
- When defined:
  - Adds output port V (1 bit), reset 0, registered together with ALU_out.
  - ADD: V = signed overflow, i.e. A[15]==B[15] and result[15]!=A[15].
  - MUL: V=1 if the upper 16 bits of the full 32-bit unsigned product are nonzero. This requires a 32-bit accumulator.
  - AND, NOT, PASSA: V=0.
- When undefined: no V port, 16-bit accumulator; ALU_out behaviour identical.

Test Plan:
- Reset then ADD: release Reset_al; Start, ALUK=000, A=0x7FFF, B=0x0001 -> one edge later ALU_out=0x8000, Done pulses 1 cycle; V=1 if ALU_OVF_FLAG_EN.
- Logic ops: AND 0xF0F0 & 0x3C3C -> 0x3030; NOT A=0x00FF -> 0xFF00; PASSA A=0x1234 -> 0x1234; each with 1-cycle latency.
- MUL: A=0x0123, B=0x0045 -> Busy high 16 cycles, Done on cycle 17 after capture, ALU_out=0x4E6F. Then A=0x1000, B=0x0010 -> ALU_out=0x0000, V=1 if enabled. Start pulses and operand changes mid-MUL -> ignored.
- Reset mid-MUL: deassert Reset_al at iteration 8 -> ALU_out=0, Busy=0, no Done; a subsequent ADD works normally.
- CC load: LD_CC with Bus_Data=0x8001 -> NZP=100; 0x0000 -> 010; 0x0005 -> 001.
- BEN: NZP=010, IR_nzp=011 with LD_BEN -> BEN=1. Same edge LD_CC (Bus_Data=0x0001) + LD_BEN with IR_nzp=001 -> BEN=0 (old NZP used), NZP becomes 001.

Source files
------------

// File: rtl/alu_cc_unit.sv
// Execute stage: registered ALU with an iterative 16-cycle shift-add MUL under Start/Done, plus LC-3 N/Z/P and BEN registers.
// Optional build macro ALU_OVF_FLAG_EN adds the V (overflow) output and widens the MUL accumulator to 32 bits.
module alu_cc_unit (
  input  logic        Clk,
  input  logic        Reset_al,
  input  logic        Start,
  input  logic [2:0]  ALUK,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] ALU_out,
  output logic        Busy,
  output logic        Done,
  input  logic [15:0] Bus_Data,
  input  logic        LD_CC,
  input  logic [2:0]  IR_nzp,
  input  logic        LD_BEN,
  output logic        N,
  output logic        Z,
  output logic        P,
  output logic        BEN
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic        V
`endif
);

  localparam int MUL_CYCLES = 16;
`ifdef ALU_OVF_FLAG_EN
  localparam int ACC_W = 32;
`else
  localparam int ACC_W = 16;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   mcand;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [15:0]        mplr;
  logic [3:0]         cnt;
  logic [15:0]        alu_res;
`ifdef ALU_OVF_FLAG_EN
  logic               alu_v;
`endif

  // Single-cycle ops; unused opcodes 101-111 fall through to PASSA.
  always_comb begin
    alu_res = A;
`ifdef ALU_OVF_FLAG_EN
    alu_v   = 1'b0;
`endif
    case (ALUK)
      OP_ADD: begin
        alu_res = A + B;
`ifdef ALU_OVF_FLAG_EN
        alu_v   = (A[15] == B[15]) && (alu_res[15] != A[15]);
`endif
      end
      OP_AND:  alu_res = A & B;
      OP_NOT:  alu_res = ~A;
      default: alu_res = A;
    endcase
  end

  assign acc_next = mplr[0] ? (acc + mcand) : acc;

  // NOTE: every register below uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state   <= S_IDLE;
      ALU_out <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
`ifdef ALU_OVF_FLAG_EN
      V       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            if (ALUK == OP_MUL) begin
              mcand <= ACC_W'(A);
              mplr  <= B;
              acc   <= '0;
              cnt   <= '0;
              Busy  <= 1'b1;
              state <= S_MUL;
            end else begin
              ALU_out <= alu_res;
`ifdef ALU_OVF_FLAG_EN
              V       <= alu_v;
`endif
              Done    <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 4'd1;
          // Last iteration: publish the final accumulator directly, not the stale register.
          if (cnt == 4'(MUL_CYCLES - 1)) begin
            ALU_out <= acc_next[15:0];
`ifdef ALU_OVF_FLAG_EN
            V       <= |acc_next[31:16];
`endif
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Condition codes and BEN run regardless of the ALU state; BEN reads the pre-edge N/Z/P.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      N   <= 1'b0;
      Z   <= 1'b0;
      P   <= 1'b0;
      BEN <= 1'b0;
    end else begin
      if (LD_CC) begin
        N <= Bus_Data[15];
        Z <= (Bus_Data == 16'h0000);
        P <= ~Bus_Data[15] & (|Bus_Data);
      end
      if (LD_BEN) begin
        BEN <= |(IR_nzp & {N, Z, P});
      end
    end
  end

endmodule

// File: tb/tb_alu_cc_unit.sv
// Scoreboard bench for alu_cc_unit: expected results queued at Start, checked when Done pulses.
// Build with +define+ALU_OVF_FLAG_EN to also check V.
module tb_alu_cc_unit;

  logic        Clk = 1'b0;
  logic        Reset_al = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  ALUK = 3'b000;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [15:0] ALU_out;
  logic        Busy;
  logic        Done;
  logic [15:0] Bus_Data = '0;
  logic        LD_CC = 1'b0;
  logic [2:0]  IR_nzp = '0;
  logic        LD_BEN = 1'b0;
  logic        N, Z, P, BEN;
`ifdef ALU_OVF_FLAG_EN
  logic        V;
`endif

  alu_cc_unit dut (
    .Clk(Clk), .Reset_al(Reset_al), .Start(Start), .ALUK(ALUK), .A(A), .B(B),
    .ALU_out(ALU_out), .Busy(Busy), .Done(Done), .Bus_Data(Bus_Data),
    .LD_CC(LD_CC), .IR_nzp(IR_nzp), .LD_BEN(LD_BEN),
    .N(N), .Z(Z), .P(P), .BEN(BEN)
`ifdef ALU_OVF_FLAG_EN
    , .V(V)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic [15:0] res;
    logic        v;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   op_id = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Output monitor: each Done pulse retires the oldest queued expectation.
  always @(negedge Clk) begin
    if (Reset_al && Done) begin
      if (q.size() == 0) begin
        check("done_unexpected", 32'(Done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("op%0d_result", e.id), 32'(ALU_out), 32'(e.res));
        check($sformatf("op%0d_latency", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
`ifdef ALU_OVF_FLAG_EN
        check($sformatf("op%0d_v", e.id), 32'(V), 32'(e.v));
`endif
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic v, input logic disturb);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    bit   is_mul;
    is_mul = (op == 3'b100);
    @(negedge Clk);
    Start = 1'b1; ALUK = op; A = a; B = b;
    e.id = op_id; e.res = res; e.v = v; e.lat = is_mul ? 17 : 1; e.start_cyc = cyc;
    q.push_back(e);
    op_id++;
    @(negedge Clk);
    Start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      busy_cnt += int'(Busy);
      if (disturb) begin
        Start = i[0]; ALUK = 3'b000; A = $urandom_range(16'hFFFF); B = $urandom_range(16'hFFFF);
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    check($sformatf("op%0d_done_seen", e.id), 32'(seen), 32'd1);
    check($sformatf("op%0d_busy_at_done", e.id), 32'(Busy), 32'd0);
    if (is_mul) check($sformatf("op%0d_busy_cycles", e.id), 32'(busy_cnt), 32'd16);
    @(negedge Clk);
    check($sformatf("op%0d_done_one_cycle", e.id), 32'(Done), 32'd0);
    check($sformatf("op%0d_hold", e.id), 32'(ALU_out), 32'(res));
  endtask

  task automatic cc_load(input logic [15:0] data, input logic [2:0] exp_nzp);
    @(negedge Clk);
    LD_CC = 1'b1; Bus_Data = data;
    @(negedge Clk);
    LD_CC = 1'b0;
    check($sformatf("nzp_%04h", data), 32'({N, Z, P}), 32'(exp_nzp));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_alu_out", 32'(ALU_out), 32'h0);
    check("rst_busy_done", 32'({Busy, Done}), 32'h0);
    check("rst_nzp_ben", 32'({N, Z, P, BEN}), 32'h0);
    @(negedge Clk);
    Reset_al = 1'b1;

    run_op(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0);
    run_op(3'b001, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
    run_op(3'b010, 16'h00FF, 16'h5555, 16'hFF00, 1'b0, 1'b0);
    run_op(3'b011, 16'h1234, 16'hAAAA, 16'h1234, 1'b0, 1'b0);
    run_op(3'b110, 16'hABCD, 16'h0001, 16'hABCD, 1'b0, 1'b0);
    run_op(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
    run_op(3'b000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0);
    run_op(3'b100, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b1);
    run_op(3'b100, 16'h1000, 16'h0010, 16'h0000, 1'b1, 1'b0);
    run_op(3'b100, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    run_op(3'b100, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0);

    // Reset mid-MUL: abort with no Done, then a normal ADD.
    @(negedge Clk);
    Start = 1'b1; ALUK = 3'b100; A = 16'h0003; B = 16'h0007;
    @(negedge Clk);
    Start = 1'b0;
    repeat (8) @(negedge Clk);
    check("mid_mul_busy", 32'(Busy), 32'd1);
    #2 Reset_al = 1'b0;
    #1;
    check("abort_alu_out", 32'(ALU_out), 32'h0);
    check("abort_busy_done", 32'({Busy, Done}), 32'h0);
    repeat (2) @(negedge Clk);
    Reset_al = 1'b1;
    repeat (20) @(negedge Clk);
    run_op(3'b000, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0);

    // Condition codes and BEN
    cc_load(16'h8001, 3'b100);
    cc_load(16'h0000, 3'b010);
    cc_load(16'h0005, 3'b001);
    cc_load(16'h0000, 3'b010);
    @(negedge Clk);
    LD_BEN = 1'b1; IR_nzp = 3'b011;
    @(negedge Clk);
    LD_BEN = 1'b0;
    check("ben_set", 32'(BEN), 32'd1);
    @(negedge Clk);
    LD_CC = 1'b1; Bus_Data = 16'h0001; LD_BEN = 1'b1; IR_nzp = 3'b001;
    @(negedge Clk);
    LD_CC = 1'b0; LD_BEN = 1'b0;
    check("ben_old_cc", 32'(BEN), 32'd0);
    check("nzp_after_same_edge", 32'({N, Z, P}), 32'b001);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
